// File: rtl/fetch_if.sv
// Fetch unit bus bundle: memory read port, opcode/immediate handshakes to decode,
// and control inputs (redirect, halt, wake).
interface fetch_if;
    typedef logic [7:0] instr_t;

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    instr_t      instr;
    logic        o_is_instr16;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  imm_len;
    logic [15:0] pc;

    logic [15:0] imm;
    logic        imm_valid;
    logic        imm_ready;

    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        wake;

    modport master (
        output mem_addr, mem_rd, instr, o_is_instr16, instr_valid, pc, imm, imm_valid,
        input  mem_rdata, mem_ack, instr_ready, imm_len, imm_ready,
               redirect, redirect_pc, halt, wake
    );

    modport slave (
        input  mem_addr, mem_rd, instr, o_is_instr16, instr_valid, pc, imm, imm_valid,
        output mem_rdata, mem_ack, instr_ready, imm_len, imm_ready,
               redirect, redirect_pc, halt, wake
    );
endinterface

// File: rtl/fetch.sv
// Byte-serial instruction fetch: reads an opcode, hands it to decode, then reads
// 0-2 little-endian immediate bytes; handles 0xCB prefix, redirect and halt/wake.
module fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_OP,
        S_IMM,
        S_IMMOUT,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  instr_q, instr_d;
    logic [15:0] imm_q, imm_d;
    logic        prefix_q, prefix_d;
    logic        halt_pend_q, halt_pend_d;
    logic        imm_two_q, imm_two_d;
    logic        imm_idx_q, imm_idx_d;
    state_e      idle_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            fetch_pc_q  <= RESET_PC;
            pc_q        <= RESET_PC;
            instr_q     <= 8'h00;
            imm_q       <= 16'h0000;
            prefix_q    <= 1'b0;
            halt_pend_q <= 1'b0;
            imm_two_q   <= 1'b0;
            imm_idx_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            prefix_q    <= prefix_d;
            halt_pend_q <= halt_pend_d;
            imm_two_q   <= imm_two_d;
            imm_idx_q   <= imm_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        prefix_d    = prefix_q;
        halt_pend_d = halt_pend_q | bus.halt;
        imm_two_d   = imm_two_q;
        imm_idx_d   = imm_idx_q;
        // a halt pulse arriving with the final handshake still parks the unit
        idle_next   = (halt_pend_q || bus.halt) ? S_HALT : S_FETCH;

        if (bus.redirect) begin
            // any in-flight ack is dropped; a same-cycle halt survives the clear
            state_d     = S_FETCH;
            fetch_pc_d  = bus.redirect_pc;
            prefix_d    = 1'b0;
            halt_pend_d = bus.halt;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        instr_d    = bus.mem_rdata;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 16'd1;
                        state_d    = S_OP;
                    end
                end
                S_OP: begin
                    if (bus.instr_ready) begin
                        if (prefix_q) begin
                            prefix_d = 1'b0;
                            state_d  = idle_next;
                        end else if (instr_q == 8'hCB) begin
                            prefix_d = 1'b1;
                            state_d  = idle_next;
                        end else if (bus.imm_len == 2'd0) begin
                            state_d = idle_next;
                        end else begin
                            state_d   = S_IMM;
                            imm_two_d = (bus.imm_len != 2'd1);
                            imm_idx_d = 1'b0;
                            imm_d     = 16'h0000;
                        end
                    end
                end
                S_IMM: begin
                    if (bus.mem_ack) begin
                        fetch_pc_d = fetch_pc_q + 16'd1;
                        imm_idx_d  = 1'b1;
                        if (imm_idx_q) imm_d[15:8] = bus.mem_rdata;
                        else           imm_d[7:0]  = bus.mem_rdata;
                        if (imm_idx_q || !imm_two_q) state_d = S_IMMOUT;
                    end
                end
                S_IMMOUT: begin
                    if (bus.imm_ready) state_d = idle_next;
                end
                S_HALT: begin
                    if (bus.wake) begin
                        halt_pend_d = 1'b0;
                        state_d     = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.mem_addr     = fetch_pc_q;
    assign bus.mem_rd       = (state_q == S_FETCH) || (state_q == S_IMM);
    assign bus.instr        = instr_q;
    assign bus.pc           = pc_q;
    assign bus.o_is_instr16 = prefix_q;
    assign bus.instr_valid  = (state_q == S_OP);
    assign bus.imm          = imm_q;
    assign bus.imm_valid    = (state_q == S_IMMOUT);
endmodule

// File: tb/tb_fetch.sv
// Directed scenarios plus a randomized run scored against a byte-stream model of
// the instruction memory.
module tb_fetch;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    fetch_if a();
    fetch_if b();

    fetch #(.RESET_PC(16'h0000)) dut_a (.clk(clk), .rst(rst_a), .bus(a));
    fetch #(.RESET_PC(16'hFFFF)) dut_b (.clk(clk), .rst(rst_b), .bus(b));

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] m_pc, m_imm, p1, p2;
    bit          m_pre, m_pend, redir;
    int          nb, wcnt, n_ins, n_imm;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        {a.mem_rdata, a.mem_ack, a.instr_ready, a.imm_len, a.imm_ready} = '0;
        {a.redirect, a.redirect_pc, a.halt, a.wake} = '0;
        {b.mem_rdata, b.mem_ack, b.instr_ready, b.imm_len, b.imm_ready} = '0;
        {b.redirect, b.redirect_pc, b.halt, b.wake} = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick(); tick();

        // reset state
        chk("rst_mem_rd", a.mem_rd, 1);
        chk("rst_instr", a.instr, 8'h00);
        chk("rst_pc", a.pc, 16'h0000);
        chk("rst_imm", a.imm, 16'h0000);
        chk("rst_ivalid", a.instr_valid, 0);
        chk("rst_imvalid", a.imm_valid, 0);

        // wrap of fetch_pc from RESET_PC=FFFF
        rst_b = 1'b0; tick();
        chk("b_addr0", b.mem_addr, 16'hFFFF);
        chk("b_rd0", b.mem_rd, 1);
        b.mem_ack = 1; b.mem_rdata = 8'h3E; tick(); b.mem_ack = 0;
        chk("b_instr", b.instr, 8'h3E);
        chk("b_pc", b.pc, 16'hFFFF);
        b.instr_ready = 1; b.imm_len = 2'd1; tick(); b.instr_ready = 0;
        chk("b_imm_addr", b.mem_addr, 16'h0000);
        chk("b_imm_rd", b.mem_rd, 1);
        b.mem_ack = 1; b.mem_rdata = 8'h5A; tick(); b.mem_ack = 0;
        chk("b_imvalid", b.imm_valid, 1);
        chk("b_imm", b.imm, 16'h005A);
        b.imm_ready = 1; tick(); b.imm_ready = 0;
        chk("b_next_addr", b.mem_addr, 16'h0001);

        // first opcode after reset, 2 wait cycles
        rst_a = 1'b0; tick();
        chk("a_first_rd", a.mem_rd, 1);
        chk("a_first_addr", a.mem_addr, 16'h0000);
        tick();
        a.mem_ack = 1; a.mem_rdata = 8'h00; tick(); a.mem_ack = 0;
        chk("op0_valid", a.instr_valid, 1);
        chk("op0_instr", a.instr, 8'h00);
        chk("op0_pc", a.pc, 16'h0000);
        a.instr_ready = 1; a.imm_len = 2'd0; tick(); a.instr_ready = 0;
        chk("op0_next", a.mem_addr, 16'h0001);
        chk("op0_valid_lo", a.instr_valid, 0);

        // two-byte immediate
        a.mem_ack = 1; a.mem_rdata = 8'h01; tick(); a.mem_ack = 0;
        chk("op1_instr", a.instr, 8'h01);
        a.instr_ready = 1; a.imm_len = 2'd2; tick(); a.instr_ready = 0;
        chk("op1_imm_a0", a.mem_addr, 16'h0002);
        a.mem_ack = 1; a.mem_rdata = 8'h34; tick();
        chk("op1_imm_a1", a.mem_addr, 16'h0003);
        a.mem_rdata = 8'h12; tick(); a.mem_ack = 0;
        chk("op1_imvalid", a.imm_valid, 1);
        chk("op1_imm", a.imm, 16'h1234);
        chk("op1_rd_lo", a.mem_rd, 0);
        a.imm_ready = 1; tick(); a.imm_ready = 0;
        chk("op1_next", a.mem_addr, 16'h0004);
        chk("op1_imvalid_lo", a.imm_valid, 0);

        // CB prefix, imm_len ignored on both transfers
        a.mem_ack = 1; a.mem_rdata = 8'hCB; tick(); a.mem_ack = 0;
        chk("cb_instr", a.instr, 8'hCB);
        chk("cb_is16", a.o_is_instr16, 0);
        a.instr_ready = 1; a.imm_len = 2'd2; tick(); a.instr_ready = 0;
        chk("cb_next", a.mem_addr, 16'h0005);
        a.mem_ack = 1; a.mem_rdata = 8'h37; tick(); a.mem_ack = 0;
        chk("cb2_instr", a.instr, 8'h37);
        chk("cb2_is16", a.o_is_instr16, 1);
        chk("cb2_pc", a.pc, 16'h0005);
        a.instr_ready = 1; a.imm_len = 2'd2; tick(); a.instr_ready = 0;
        chk("cb2_next", a.mem_addr, 16'h0006);
        chk("cb2_is16_lo", a.o_is_instr16, 0);
        a.mem_ack = 1; a.mem_rdata = 8'h00; tick(); a.mem_ack = 0;
        chk("cb3_pc", a.pc, 16'h0006);
        a.instr_ready = 1; a.imm_len = 2'd0; tick(); a.instr_ready = 0;

        // redirect during immediate read with a same-cycle ack
        a.mem_ack = 1; a.mem_rdata = 8'h3E; tick(); a.mem_ack = 0;
        a.instr_ready = 1; a.imm_len = 2'd1; tick(); a.instr_ready = 0;
        chk("rd_imm_addr", a.mem_addr, 16'h0008);
        a.mem_ack = 1; a.mem_rdata = 8'hAA; a.redirect = 1; a.redirect_pc = 16'h0150;
        tick();
        a.mem_ack = 0; a.redirect = 0;
        chk("rd_addr", a.mem_addr, 16'h0150);
        chk("rd_rd", a.mem_rd, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rd_imvalid", a.imm_valid, 0);
            chk("rd_ivalid", a.instr_valid, 0);
            tick();
        end
        a.mem_ack = 1; a.mem_rdata = 8'h00; tick(); a.mem_ack = 0;
        chk("rd_op_pc", a.pc, 16'h0150);

        // halt while presenting an opcode, then wake
        a.halt = 1; tick(); a.halt = 0;
        chk("h_still_valid", a.instr_valid, 1);
        a.instr_ready = 1; a.imm_len = 2'd0; tick(); a.instr_ready = 0;
        for (int i = 0; i < 10; i++) begin
            chk("h_rd", a.mem_rd, 0);
            chk("h_ivalid", a.instr_valid, 0);
            tick();
        end
        a.wake = 1; tick(); a.wake = 0;
        chk("w_rd", a.mem_rd, 1);
        chk("w_addr", a.mem_addr, 16'h0151);

        // reset mid-read with a concurrent ack
        rst_a = 1; a.mem_ack = 1; a.mem_rdata = 8'h77; tick();
        rst_a = 0; a.mem_ack = 0; tick();
        chk("mr_addr", a.mem_addr, 16'h0000);
        chk("mr_instr", a.instr, 8'h00);
        chk("mr_ivalid", a.instr_valid, 0);

        // randomized run against the memory byte-stream model
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'hCB : 8'($urandom);
        rst_a = 1; tick(); tick(); rst_a = 0;
        m_pc = 16'h0000; m_pre = 0; m_pend = 0; m_imm = '0;
        wcnt = 1; n_ins = 0; n_imm = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            redir = ($urandom_range(0, 59) == 0);
            a.redirect    = redir;
            a.redirect_pc = 16'($urandom);
            a.mem_ack     = a.mem_rd && (wcnt == 0);
            a.mem_rdata   = mem[a.mem_addr];
            a.instr_ready = 1'($urandom_range(0, 1));
            a.imm_len     = 2'($urandom_range(0, 3));
            a.imm_ready   = 1'($urandom_range(0, 1));
            if (redir) begin
                m_pc = a.redirect_pc; m_pre = 0; m_pend = 0;
            end else begin
                if (a.instr_valid && a.instr_ready) begin
                    chk("rnd_no_pend", m_pend, 0);
                    chk("rnd_instr", a.instr, mem[m_pc]);
                    chk("rnd_pc", a.pc, m_pc);
                    chk("rnd_is16", a.o_is_instr16, m_pre);
                    n_ins++;
                    p1 = m_pc + 16'd1;
                    p2 = m_pc + 16'd2;
                    if (m_pre) begin
                        m_pre = 0; m_pc = p1;
                    end else if (mem[m_pc] == 8'hCB) begin
                        m_pre = 1; m_pc = p1;
                    end else begin
                        nb = (a.imm_len == 2'd0) ? 0 : (a.imm_len == 2'd1) ? 1 : 2;
                        if (nb == 1) m_imm = {8'h00, mem[p1]};
                        else         m_imm = {mem[p2], mem[p1]};
                        m_pend = (nb != 0);
                        m_pc   = m_pc + 16'(1 + nb);
                    end
                end
                if (a.imm_valid && a.imm_ready) begin
                    chk("rnd_imm_pend", m_pend, 1);
                    chk("rnd_imm", a.imm, m_imm);
                    m_pend = 0;
                    n_imm++;
                end
            end
            if (a.mem_ack || redir) wcnt = $urandom_range(0, 2);
            else if (a.mem_rd && wcnt > 0) wcnt--;
            tick();
        end
        a.redirect = 0; a.mem_ack = 0; a.instr_ready = 0; a.imm_ready = 0;
        chk("rnd_progress_ins", (n_ins > 100), 1);
        chk("rnd_progress_imm", (n_imm > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
